// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that shares a single ALU between two requesters and
// returns each result, with its overflow flag, on a valid/ready response channel.
module alu_share_ctrl #(
    parameter int DATA_W  = 6,
    parameter int LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    input  logic [1:0][2:0]        req_op,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [2:0]             alu_select,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic                   alu_of,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_of,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam logic [2:0] PARK  = 3'b010;
    localparam int         CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_grant;
    logic             grant;
    logic             any_valid;
    logic             op_illegal;

    // With both requesters valid the one not served last time wins.
    always_comb begin
        any_valid  = |req_valid;
        grant      = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        op_illegal = (req_op[grant][2:1] == 2'b01);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 2'b00;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready[grant] = 1'b1;
                    next_state       = op_illegal ? RESP : ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // ALU drive is registered so it is visible exactly during ISSUE and WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= PARK;
            wait_cnt   <= '0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_of     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        last_grant <= grant;
                        rsp_id     <= grant;
                        if (op_illegal) begin
                            rsp_data <= '0;
                            rsp_of   <= 1'b0;
                            rsp_err  <= 1'b1;
                        end else begin
                            alu_a      <= req_a[grant];
                            alu_b      <= req_b[grant];
                            alu_select <= req_op[grant];
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_W'(LATENCY - 1);
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_data   <= alu_result;
                        rsp_of     <= alu_of;
                        rsp_err    <= 1'b0;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        alu_select <= PARK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
